// File: rtl/namuru_pkg.sv
// Shared constants and types for the correlator readout block.
// - ACC_W_DEFAULT : default accumulation width
// - slot_e        : slot order within one channel's shadow bank
// - CH_STRIDE     : word stride between channels in the address map
// - STATUS_OFS / OVERRUN_OFS : status words, relative to NUM_CHAN*CH_STRIDE
package namuru_pkg;

    localparam int ACC_W_DEFAULT = 16;
    localparam int NUM_SLOTS     = 6;
    localparam int CH_STRIDE     = 8;
    localparam int STATUS_OFS    = 0;
    localparam int OVERRUN_OFS   = 1;

    typedef enum logic [2:0] {
        SLOT_IE = 3'd0,
        SLOT_QE = 3'd1,
        SLOT_IP = 3'd2,
        SLOT_QP = 3'd3,
        SLOT_IL = 3'd4,
        SLOT_QL = 3'd5
    } slot_e;

endpackage

// File: rtl/accum_readout_chan.sv
// One tracking channel's readout state: six shadow accumulations captured on
// the dump pulse, plus the new_data and overrun flags.
// Ports:
//   clk, rstn  - clock, synchronous active-low reset
//   dump       - capture strobe (1 clk wide)
//   acc_in     - six accumulations, slot k at [k*ACC_W +: ACC_W]
//   clear_new  - the ql slot of this channel is being read
//   clear_ovr  - the overrun register is being read
//   shadow     - captured accumulations, same packing as acc_in
//   new_data   - unread capture pending
//   overrun    - a capture was overwritten before it was read
module accum_readout_chan
    import namuru_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       dump,
    input  logic [NUM_SLOTS*ACC_W-1:0] acc_in,
    input  logic                       clear_new,
    input  logic                       clear_ovr,
    output logic [NUM_SLOTS*ACC_W-1:0] shadow,
    output logic                       new_data,
    output logic                       overrun
);

    // An overwrite only counts when the previous capture is still unread and
    // is not being consumed by a ql read at this very edge.
    logic ovr_set;
    assign ovr_set = dump && new_data && !clear_new;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shadow   <= '0;
            new_data <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (dump) begin
                shadow <= acc_in;
            end
            // Capture beats a concurrent clear of new_data.
            if (dump) begin
                new_data <= 1'b1;
            end else if (clear_new) begin
                new_data <= 1'b0;
            end
            // A fresh overrun beats the clear-on-read of the overrun register,
            // so the event surfaces on the next read instead of being lost.
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clear_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/accum_readout.sv
// Reader side of the tracking-channel correlator outputs. Captures each
// channel's six accumulations on its dump pulse and serves them, together with
// per-channel new_data / overrun status, over a registered word-read port.
// Ports:
//   clk, rstn  - clock, synchronous active-low reset
//   dump       - per-channel capture pulse
//   acc_in     - channel c slot k at [(c*6+k)*ACC_W +: ACC_W]
//   rd_en      - read strobe
//   rd_addr    - word address (ch*8+k, NUM_CHAN*8 status, NUM_CHAN*8+1 overrun)
//   rd_data    - read data, one cycle after rd_en, held while idle
//   rd_valid   - one-cycle pulse per read
//   new_data   - per-channel unread-capture flags
//   irq        - registered OR of new_data
module accum_readout
    import namuru_pkg::*;
#(
    parameter int NUM_CHAN = 12,
    parameter int ACC_W    = ACC_W_DEFAULT,
    parameter int ADDR_W   = 7
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [NUM_CHAN-1:0]                 dump,
    input  logic [NUM_CHAN*NUM_SLOTS*ACC_W-1:0] acc_in,
    input  logic                                rd_en,
    input  logic [ADDR_W-1:0]                   rd_addr,
    output logic [31:0]                         rd_data,
    output logic                                rd_valid,
    output logic [NUM_CHAN-1:0]                 new_data,
    output logic                                irq
);

    localparam logic [ADDR_W-1:0] STATUS_ADDR  = ADDR_W'(NUM_CHAN*CH_STRIDE + STATUS_OFS);
    localparam logic [ADDR_W-1:0] OVERRUN_ADDR = ADDR_W'(NUM_CHAN*CH_STRIDE + OVERRUN_OFS);

    function automatic logic [31:0] sext32(input logic signed [ACC_W-1:0] v);
        return 32'(v);
    endfunction

    logic [NUM_SLOTS*ACC_W-1:0] shadow_bus [NUM_CHAN];
    logic [NUM_CHAN-1:0]        overrun;
    logic [NUM_CHAN-1:0]        clear_new;
    logic                       clear_ovr;
    logic [31:0]                rd_word_p0;

    genvar gc;
    generate
        for (gc = 0; gc < NUM_CHAN; gc++) begin : g_chan
            accum_readout_chan #(
                .ACC_W(ACC_W)
            ) u_chan (
                .clk      (clk),
                .rstn     (rstn),
                .dump     (dump[gc]),
                .acc_in   (acc_in[gc*NUM_SLOTS*ACC_W +: NUM_SLOTS*ACC_W]),
                .clear_new(clear_new[gc]),
                .clear_ovr(clear_ovr),
                .shadow   (shadow_bus[gc]),
                .new_data (new_data[gc]),
                .overrun  (overrun[gc])
            );
        end
    endgenerate

    assign clear_ovr = rd_en && (rd_addr == OVERRUN_ADDR);

    always_comb begin
        clear_new = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            clear_new[c] = rd_en && (rd_addr == ADDR_W'(c*CH_STRIDE + int'(SLOT_QL)));
        end
    end

    // Stage p0: read mux over pre-update state; unmapped words read as zero.
    always_comb begin
        rd_word_p0 = '0;
        if (rd_addr == STATUS_ADDR) begin
            rd_word_p0 = {{(32-NUM_CHAN){1'b0}}, new_data};
        end else if (rd_addr == OVERRUN_ADDR) begin
            rd_word_p0 = {{(32-NUM_CHAN){1'b0}}, overrun};
        end else begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                for (int k = 0; k < NUM_SLOTS; k++) begin
                    if (rd_addr == ADDR_W'(c*CH_STRIDE + k)) begin
                        rd_word_p0 = sext32(shadow_bus[c][k*ACC_W +: ACC_W]);
                    end
                end
            end
        end
    end

    // Stage p1: registered read port and interrupt.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            irq      <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_word_p0;
            end
            irq <= |new_data;
        end
    end

endmodule

// File: tb/tb_accum_readout.sv
module tb_accum_readout;

    localparam int NUM_CHAN = 12;
    localparam int ACC_W    = 16;
    localparam int ADDR_W   = 7;

    logic                          clk;
    logic                          rstn;
    logic [NUM_CHAN-1:0]           dump;
    logic [NUM_CHAN*6*ACC_W-1:0]   acc_in;
    logic                          rd_en;
    logic [ADDR_W-1:0]             rd_addr;
    logic [31:0]                   rd_data;
    logic                          rd_valid;
    logic [NUM_CHAN-1:0]           new_data;
    logic                          irq;

    int tests;
    int fails;

    accum_readout #(
        .NUM_CHAN(NUM_CHAN),
        .ACC_W   (ACC_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .dump    (dump),
        .acc_in  (acc_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .new_data(new_data),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int c, input int k, input logic [15:0] v);
        acc_in[(c*6+k)*ACC_W +: ACC_W] = v;
    endtask

    // Single read: strobe for one edge, then idle; result is visible after tick.
    task automatic do_read(input int addr);
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(addr);
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; dump = '0; acc_in = '0; rd_en = 1'b0; rd_addr = '0;
        tick(); tick();
        tests++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0 || new_data !== '0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: valid=%b data=%h new=%h irq=%b, want 0/0/0/0",
                     rd_valid, rd_data, new_data, irq);
        end
        rstn = 1'b1;
        tick();
        // back-to-back reads of the whole map
        for (int a = 0; a < 98; a++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(a);
            tick();
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
                fails++;
                $display("FAIL reset_read[%0d]: valid=%b data=%h, want 1/00000000", a, rd_valid, rd_data);
            end
        end
        rd_en = 1'b0;
        tick();
        tests++;
        if (rd_valid !== 1'b0 || new_data !== '0 || irq !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: valid=%b new=%h irq=%b, want 0/000/0", rd_valid, new_data, irq);
        end
    endtask

    task automatic test_capture();
        logic [31:0] exp_w [6];
        logic [15:0] vals  [6];
        vals  = '{16'hFFFB, 16'h0007, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF};
        exp_w = '{32'hFFFFFFFB, 32'h00000007, 32'hFFFF8000, 32'h00007FFF, 32'h00000001, 32'hFFFFFFFF};
        for (int k = 0; k < 6; k++) set_slot(3, k, vals[k]);
        dump = 12'h008;
        tick();
        dump = '0;
        tests++;
        if (new_data !== 12'h008 || irq !== 1'b0) begin
            fails++;
            $display("FAIL capture_flag: new=%h irq=%b, want 008/0", new_data, irq);
        end
        tick();
        tests++;
        if (irq !== 1'b1) begin
            fails++;
            $display("FAIL capture_irq: irq=%b, want 1", irq);
        end
        for (int k = 0; k < 6; k++) begin
            rd_en = 1'b1; rd_addr = ADDR_W'(24 + k);
            tick();
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== exp_w[k]) begin
                fails++;
                $display("FAIL capture_read[%0d]: valid=%b data=%h, want 1/%h", 24 + k, rd_valid, rd_data, exp_w[k]);
            end
            if (k == 4) begin
                tests++;
                if (new_data !== 12'h008) begin
                    fails++;
                    $display("FAIL capture_noclr_il: new=%h, want 008", new_data);
                end
            end
        end
        rd_en = 1'b0;
        tests++;
        if (new_data !== 12'h000 || irq !== 1'b1) begin
            fails++;
            $display("FAIL capture_clear: new=%h irq=%b, want 000/1", new_data, irq);
        end
        tick();
        tests++;
        if (irq !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL capture_irq_fall: irq=%b valid=%b data=%h, want 0/0/ffffffff", irq, rd_valid, rd_data);
        end
    endtask

    task automatic test_overrun();
        set_slot(0, 5, 16'h1111);
        dump = 12'h001; tick();
        set_slot(0, 5, 16'h1234);
        tick();
        dump = '0;
        do_read(97);
        tests++;
        if (rd_data !== 32'h1) begin
            fails++;
            $display("FAIL overrun_read1: data=%h, want 00000001", rd_data);
        end
        do_read(97);
        tests++;
        if (rd_data !== 32'h0) begin
            fails++;
            $display("FAIL overrun_read2: data=%h, want 00000000", rd_data);
        end
        do_read(96);
        tests++;
        if (rd_data !== 32'h1) begin
            fails++;
            $display("FAIL overrun_status: data=%h, want 00000001", rd_data);
        end
        // dump on ch1 at the same edge as the overrun read
        dump = 12'h002; tick();
        rd_en = 1'b1; rd_addr = ADDR_W'(97);
        tick();
        dump = '0; rd_en = 1'b0;
        tests++;
        if (rd_data !== 32'h0) begin
            fails++;
            $display("FAIL overrun_same_edge: data=%h, want 00000000", rd_data);
        end
        do_read(97);
        tests++;
        if (rd_data !== 32'h2) begin
            fails++;
            $display("FAIL overrun_after_same_edge: data=%h, want 00000002", rd_data);
        end
        do_read(13);
        tests++;
        if (new_data !== 12'h001) begin
            fails++;
            $display("FAIL overrun_ch1_clear: new=%h, want 001", new_data);
        end
    endtask

    task automatic test_simul_dump_read();
        set_slot(0, 5, 16'hFFFE);
        dump = 12'h001; rd_en = 1'b1; rd_addr = ADDR_W'(5);
        tick();
        dump = '0; rd_en = 1'b0;
        tests++;
        if (rd_data !== 32'h00001234 || new_data !== 12'h001) begin
            fails++;
            $display("FAIL simul_old_ql: data=%h new=%h, want 00001234/001", rd_data, new_data);
        end
        do_read(97);
        tests++;
        if (rd_data !== 32'h0) begin
            fails++;
            $display("FAIL simul_no_overrun: data=%h, want 00000000", rd_data);
        end
        do_read(5);
        tests++;
        if (rd_data !== 32'hFFFFFFFE || new_data !== 12'h000) begin
            fails++;
            $display("FAIL simul_new_ql: data=%h new=%h, want fffffffe/000", rd_data, new_data);
        end
    endtask

    task automatic test_unmapped();
        do_read(24);
        tick();
        tests++;
        if (rd_valid !== 1'b0 || rd_data !== 32'hFFFFFFFB) begin
            fails++;
            $display("FAIL hold_data: valid=%b data=%h, want 0/fffffffb", rd_valid, rd_data);
        end
        do_read(120);
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0 || new_data !== 12'h000) begin
            fails++;
            $display("FAIL addr_120: valid=%b data=%h new=%h, want 1/00000000/000", rd_valid, rd_data, new_data);
        end
        do_read(6);
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0 || new_data !== 12'h000) begin
            fails++;
            $display("FAIL addr_6: valid=%b data=%h new=%h, want 1/00000000/000", rd_valid, rd_data, new_data);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 6; k++) set_slot(2, k, 16'(16'h0100 + k));
        dump = 12'h004; tick(); dump = '0;
        do_read(16);
        tests++;
        if (rd_data !== 32'h00000100 || new_data !== 12'h004) begin
            fails++;
            $display("FAIL mid_precap: data=%h new=%h, want 00000100/004", rd_data, new_data);
        end
        for (int k = 0; k < 6; k++) set_slot(2, k, 16'(16'h0200 + k));
        dump = 12'h004; rd_en = 1'b1; rd_addr = ADDR_W'(18); rstn = 1'b0;
        tick();
        dump = '0; rd_en = 1'b0; rstn = 1'b1;
        tests++;
        if (rd_valid !== 1'b0 || rd_data !== 32'h0 || new_data !== 12'h000) begin
            fails++;
            $display("FAIL mid_reset: valid=%b data=%h new=%h, want 0/00000000/000", rd_valid, rd_data, new_data);
        end
        for (int k = 0; k < 6; k++) begin
            do_read(16 + k);
            tests++;
            if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
                fails++;
                $display("FAIL mid_shadow[%0d]: valid=%b data=%h, want 1/00000000", 16 + k, rd_valid, rd_data);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_capture();
        test_overrun();
        test_simul_dump_read();
        test_unmapped();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
